// File: rtl/aes_ctr_pkg.sv
// Shared types and constants for the AES-CTR sequencer.
package aes_ctr_pkg;

    localparam int unsigned BLK_W           = 128;
    localparam int unsigned CNT_W           = 32;
    localparam int unsigned TIMEOUT_CYC_DEF = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_e;

    // One captured stream beat: payload block plus end-of-message flag.
    typedef struct packed {
        logic [BLK_W-1:0] data;
        logic             last;
    } blk_t;

endpackage

// File: rtl/aes_ctr_ctrl.sv
// AES-CTR sequencer: issues one counter block at a time to an external AES core and XORs the keystream with the payload.
// Optional WAIT watchdog is built when AES_CTR_TIMEOUT_EN is defined.
module aes_ctr_ctrl
    import aes_ctr_pkg::*;
#(
    parameter int unsigned CTR_W       = 32,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [BLK_W-1:0] cfg_key,
    input  logic [BLK_W-1:0] cfg_iv,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [BLK_W-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [BLK_W-1:0] m_data,
    output logic             m_last,
    output logic             core_start,
    output logic             core_encrypt,
    output logic [BLK_W-1:0] core_data_in,
    output logic [BLK_W-1:0] core_key_in,
    input  logic [BLK_W-1:0] core_data_out,
    input  logic             core_busy,
    input  logic             core_done,
    output logic [CNT_W-1:0] blk_count,
    output logic             err_timeout
);

    // Only the low CTR_W bits of the counter block advance; the rest is a fixed nonce.
    localparam logic [BLK_W-1:0] CTR_MASK =
        (CTR_W >= BLK_W) ? {BLK_W{1'b1}} : ((BLK_W'(1) << CTR_W) - BLK_W'(1));

    state_e           state_q, state_d;
    logic [BLK_W-1:0] ctr_q, ctr_d;
    logic [BLK_W-1:0] key_q, key_d;
    blk_t             beat_q, beat_d;
    logic [BLK_W-1:0] m_data_q, m_data_d;
    logic             m_last_q, m_last_d;
    logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;

`ifdef AES_CTR_TIMEOUT_EN
    localparam int unsigned     TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            err_q, err_d;
`endif

    // core_busy is advisory only; completion is signalled by core_done.
    logic unused_inputs;
    assign unused_inputs = ^{core_busy, 32'(TIMEOUT_CYC)};

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        ctr_d     = ctr_q;
        key_d     = key_q;
        beat_d    = beat_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        blk_cnt_d = blk_cnt_q;
        s_ready   = 1'b0;
`ifdef AES_CTR_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        err_d      = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (cfg_load) begin
                    ctr_d = cfg_iv;
                    key_d = cfg_key;
                end else begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        beat_d.data = s_data;
                        beat_d.last = s_last;
                        state_d     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef AES_CTR_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            WAIT: begin
                if (core_done) begin
                    m_data_d = core_data_out ^ beat_q.data;
                    m_last_d = beat_q.last;
                    ctr_d    = (ctr_q & ~CTR_MASK) | ((ctr_q + BLK_W'(1)) & CTR_MASK);
                    state_d  = OUT;
                end
`ifdef AES_CTR_TIMEOUT_EN
                else if (wait_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                end
`endif
            end
            OUT: begin
                if (m_ready) begin
                    blk_cnt_d = blk_cnt_q + CNT_W'(1);
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ctr_q     <= '0;
            key_q     <= '0;
            beat_q    <= '0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            blk_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ctr_q     <= ctr_d;
            key_q     <= key_d;
            beat_q    <= beat_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

`ifdef AES_CTR_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    // Core operands come straight from the registers, so they stay put until core_done.
    assign core_start   = (state_q == ISSUE);
    assign core_encrypt = 1'b1;
    assign core_data_in = ctr_q;
    assign core_key_in  = key_q;

    assign m_valid   = (state_q == OUT);
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign blk_count = blk_cnt_q;

endmodule

// File: tb/tb_aes_ctr_ctrl.sv
// Self-checking bench for aes_ctr_ctrl: stub AES core with variable latency plus a CTR-mode reference model.
module tb_aes_ctr_ctrl;

    localparam int unsigned CTR_W       = 32;
    localparam int unsigned TIMEOUT_CYC = 64;

    localparam logic [127:0] NIST_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] NIST_IV  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] NIST_IV1 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
    localparam logic [127:0] NIST_KS0 = 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
    localparam logic [127:0] NIST_KS1 = 128'h362b7c3c6773516318a077d7fc5073ae;
    localparam logic [127:0] PT0      = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] PT1      = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] CT0      = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] CT1      = 128'h9806f66b7970fdff8617187bb9fffdff;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_load;
    logic [127:0] cfg_key, cfg_iv;
    logic         s_valid, s_ready, s_last;
    logic [127:0] s_data;
    logic         m_valid, m_ready, m_last;
    logic [127:0] m_data;
    logic         core_start, core_encrypt, core_busy, core_done;
    logic [127:0] core_data_in, core_key_in, core_data_out;
    logic [31:0]  blk_count;
    logic         err_timeout;

    aes_ctr_ctrl #(.CTR_W(CTR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst),
        .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .core_start(core_start), .core_encrypt(core_encrypt),
        .core_data_in(core_data_in), .core_key_in(core_key_in),
        .core_data_out(core_data_out), .core_busy(core_busy), .core_done(core_done),
        .blk_count(blk_count), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [127:0] key_m, ctr_m;
    int unsigned  blk_m;

    // Stub core controls and observations
    bit           core_mute    = 1'b0;
    int           core_lat_min = 1;
    int           core_lat_max = 4;
    int           rst_epoch    = 0;
    int           start_cyc    = -1;
    int           done_cyc     = -1;
    int           unstable_cnt = 0;
    logic [127:0] last_cin     = '0;
    logic [127:0] last_kin     = '0;
    logic [127:0] c_cin, c_kin;
    int           c_lat, c_ep;

    // Stand-in block cipher: real AES outputs for the two NIST counter blocks, a keyed mix elsewhere.
    function automatic logic [127:0] fake_aes(input logic [127:0] k, input logic [127:0] d);
        if (k == NIST_KEY && d == NIST_IV)  return NIST_KS0;
        if (k == NIST_KEY && d == NIST_IV1) return NIST_KS1;
        return {k[63:0] ^ d[127:64], k[127:64] + d[63:0]} ^ {4{d[31:0] * 32'h9e3779b1}};
    endfunction

    function automatic logic [127:0] ctr_next(input logic [127:0] c);
        return {c[127:32], c[31:0] + 32'd1};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Stub AES core: latches operands on core_start, answers after a random number of cycles.
    initial begin
        core_done     = 1'b0;
        core_busy     = 1'b0;
        core_data_out = '0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (core_start === 1'b1 && !core_mute) begin
                c_cin     = core_data_in;
                c_kin     = core_key_in;
                c_ep      = rst_epoch;
                start_cyc = cyc;
                last_cin  = c_cin;
                last_kin  = c_kin;
                core_busy = 1'b1;
                c_lat     = $urandom_range(core_lat_max, core_lat_min);
                for (int i = 0; i < c_lat; i++) begin
                    @(negedge clk);
                    if (c_ep == rst_epoch && (core_data_in !== c_cin || core_key_in !== c_kin))
                        unstable_cnt++;
                end
                core_data_out = fake_aes(c_kin, c_cin);
                core_done     = 1'b1;
                core_busy     = 1'b0;
                done_cyc      = cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_cfg(input logic [127:0] key, input logic [127:0] iv);
        cfg_key  = key;
        cfg_iv   = iv;
        cfg_load = 1'b1;
        #1;
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL s_ready_on_load: got %b expected 0", s_ready);
        end
        @(negedge clk);
        cfg_load = 1'b0;
        key_m    = key;
        ctr_m    = iv;
    endtask

    // Push one block, wait for its result, hold backpressure for 'hold' cycles, then accept it.
    task automatic send_block(input logic [127:0] data, input logic last, input int hold,
                              output logic [127:0] obs_d, output logic obs_l);
        int           h_cyc, v_cyc;
        bit           got;
        logic [127:0] exp_d;
        exp_d  = fake_aes(key_m, ctr_m) ^ data;
        obs_d  = 'x;
        obs_l  = 1'bx;
        s_data = data;
        s_last = last;
        s_valid = 1'b1;
        got = 1'b0;
        h_cyc = 0;
        for (int i = 0; i < 16 && !got; i++) begin
            #1;
            if (s_ready === 1'b1) begin
                got   = 1'b1;
                h_cyc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL in_handshake: s_ready stayed %b for 16 cycles, expected 1", s_ready);
            s_valid = 1'b0;
            return;
        end
        @(negedge clk);
        s_valid = 1'b0;
        got = 1'b0;
        v_cyc = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (m_valid === 1'b1) begin
                got   = 1'b1;
                v_cyc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL out_valid: m_valid stayed %b for 200 cycles, expected 1", m_valid);
            return;
        end
        obs_d = m_data;
        obs_l = m_last;
        n_checks++;
        if (start_cyc !== h_cyc + 1) begin
            n_fail++;
            $display("FAIL start_latency: core_start at cycle %0d expected %0d", start_cyc, h_cyc + 1);
        end
        n_checks++;
        if (v_cyc !== done_cyc + 1) begin
            n_fail++;
            $display("FAIL valid_latency: m_valid at cycle %0d expected %0d", v_cyc, done_cyc + 1);
        end
        n_checks++;
        if (last_cin !== ctr_m) begin
            n_fail++;
            $display("FAIL core_data_in: got %h expected %h", last_cin, ctr_m);
        end
        n_checks++;
        if (last_kin !== key_m) begin
            n_fail++;
            $display("FAIL core_key_in: got %h expected %h", last_kin, key_m);
        end
        n_checks++;
        if (unstable_cnt !== 0) begin
            n_fail++;
            $display("FAIL core_in_stable: %0d operand changes before core_done, expected 0", unstable_cnt);
        end
        n_checks++;
        if (m_data !== exp_d) begin
            n_fail++;
            $display("FAIL m_data: got %h expected %h", m_data, exp_d);
        end
        n_checks++;
        if (m_last !== last) begin
            n_fail++;
            $display("FAIL m_last: got %b expected %b", m_last, last);
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== obs_d || m_last !== obs_l || s_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold: valid=%b data=%h last=%b s_ready=%b expected 1 %h %b 0",
                         m_valid, m_data, m_last, s_ready, obs_d, obs_l);
            end
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        ctr_m   = ctr_next(ctr_m);
        blk_m   = blk_m + 1;
        n_checks++;
        if (blk_count !== blk_m) begin
            n_fail++;
            $display("FAIL blk_count: got %0d expected %0d", blk_count, blk_m);
        end
        n_checks++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL m_valid_after_accept: got %b expected 0", m_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({m_valid, m_last, core_start, err_timeout} !== 4'b0000 || m_data !== '0 || blk_count !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b last=%b start=%b err=%b data=%h cnt=%0d expected all 0",
                     m_valid, m_last, core_start, err_timeout, m_data, blk_count);
        end
        n_checks++;
        if (core_data_in !== '0 || core_key_in !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: ctr=%h key=%h expected 0", core_data_in, core_key_in);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (s_ready !== 1'b1 || core_encrypt !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset: s_ready=%b core_encrypt=%b expected 1 1", s_ready, core_encrypt);
        end
        key_m = '0;
        ctr_m = '0;
        blk_m = 0;
    endtask

    task automatic test_ctr_vector();
        logic [127:0] od;
        logic         ol;
        load_cfg(NIST_KEY, NIST_IV);
        send_block(PT0, 1'b0, 0, od, ol);
        n_checks++;
        if (od !== CT0) begin
            n_fail++;
            $display("FAIL nist_block0: got %h expected %h", od, CT0);
        end
        send_block(PT1, 1'b1, 2, od, ol);
        n_checks++;
        if (od !== CT1 || ol !== 1'b1) begin
            n_fail++;
            $display("FAIL nist_block1: got %h last %b expected %h last 1", od, ol, CT1);
        end
        n_checks++;
        if (blk_count !== 32'd2) begin
            n_fail++;
            $display("FAIL nist_count: got %0d expected 2", blk_count);
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] od;
        logic         ol;
        load_cfg(NIST_KEY, NIST_IV);
        send_block(CT0, 1'b1, 0, od, ol);
        n_checks++;
        if (od !== PT0) begin
            n_fail++;
            $display("FAIL round_trip: got %h expected %h", od, PT0);
        end
    endtask

    task automatic test_wrap();
        logic [127:0] od, iv;
        logic         ol;
        iv = rand128();
        iv[31:0] = 32'hffffffff;
        load_cfg(rand128(), iv);
        send_block(rand128(), 1'b0, 0, od, ol);
        send_block(rand128(), 1'b1, 0, od, ol);
        n_checks++;
        if (last_cin[31:0] !== 32'h0 || last_cin[127:32] !== iv[127:32]) begin
            n_fail++;
            $display("FAIL ctr_wrap: got %h expected %h", last_cin, {iv[127:32], 32'h0});
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] od;
        logic         ol;
        load_cfg(rand128(), rand128());
        send_block(rand128(), 1'b0, 10, od, ol);
        send_block(rand128(), 1'b1, 10, od, ol);
    endtask

    task automatic test_load_with_valid();
        logic [127:0] od, d;
        logic         ol;
        d       = rand128();
        s_data  = d;
        s_last  = 1'b0;
        s_valid = 1'b1;
        load_cfg(rand128(), rand128());
        #1;
        n_checks++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_beats_valid: s_ready %b after load, expected 1 (still idle)", s_ready);
        end
        send_block(d, 1'b0, 0, od, ol);
    endtask

    task automatic test_load_in_wait();
        logic [127:0] od;
        logic         ol;
        core_lat_min = 8;
        core_lat_max = 8;
        fork
            send_block(rand128(), 1'b0, 0, od, ol);
            begin
                repeat (3) @(negedge clk);
                cfg_key  = rand128();
                cfg_iv   = rand128();
                cfg_load = 1'b1;
                @(negedge clk);
                cfg_load = 1'b0;
            end
        join
        core_lat_min = 1;
        core_lat_max = 4;
        send_block(rand128(), 1'b1, 1, od, ol);
    endtask

    task automatic test_random();
        logic [127:0] od;
        logic         ol;
        core_lat_min = 1;
        core_lat_max = 6;
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(5, 0) == 0)
                load_cfg(rand128(), rand128());
            send_block(rand128(), 1'($urandom_range(1, 0)), int'($urandom_range(3, 0)), od, ol);
        end
        core_lat_max = 4;
    endtask

    task automatic test_reset_mid_wait();
        int late;
        core_lat_min = 12;
        core_lat_max = 12;
        s_data  = rand128();
        s_last  = 1'b1;
        s_valid = 1'b1;
        #1;
        n_checks++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_wait_start: s_ready %b expected 1", s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        rst_epoch++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (m_valid !== 1'b0 || blk_count !== '0 || core_start !== 1'b0 || m_data !== '0 || m_last !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_wait: valid=%b cnt=%0d start=%b data=%h last=%b expected all 0",
                     m_valid, blk_count, core_start, m_data, m_last);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_wait_idle: s_ready %b expected 1", s_ready);
        end
        late = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_valid === 1'b1) late++;
        end
        n_checks++;
        if (late !== 0) begin
            n_fail++;
            $display("FAIL late_done: m_valid seen %0d cycles after reset, expected 0", late);
        end
        key_m = '0;
        ctr_m = '0;
        blk_m = 0;
        core_lat_min = 1;
        core_lat_max = 4;
    endtask

    task automatic test_timeout();
        int           h_cyc, e_cyc, mv;
        bit           got;
        logic [127:0] od;
        logic         ol;
        load_cfg(rand128(), rand128());
        core_mute = 1'b1;
        s_data  = rand128();
        s_last  = 1'b0;
        s_valid = 1'b1;
        #1;
        h_cyc = cyc;
        n_checks++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_start: s_ready %b expected 1", s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
`ifdef AES_CTR_TIMEOUT_EN
        got   = 1'b0;
        e_cyc = 0;
        mv    = 0;
        for (int i = 0; i < int'(TIMEOUT_CYC) + 20 && !got; i++) begin
            @(negedge clk);
            if (m_valid === 1'b1) mv++;
            if (err_timeout === 1'b1) begin
                got   = 1'b1;
                e_cyc = cyc;
            end
        end
        n_checks++;
        if (!got || e_cyc !== h_cyc + 2 + int'(TIMEOUT_CYC)) begin
            n_fail++;
            $display("FAIL err_timeout_cycle: pulse seen=%b at cycle %0d expected cycle %0d",
                     got, e_cyc, h_cyc + 2 + int'(TIMEOUT_CYC));
        end
        n_checks++;
        if (mv !== 0) begin
            n_fail++;
            $display("FAIL timeout_no_output: m_valid seen %0d cycles, expected 0", mv);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (err_timeout !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_pulse_idle: err=%b s_ready=%b expected 0 1", err_timeout, s_ready);
        end
        core_mute = 1'b0;
        send_block(rand128(), 1'b1, 0, od, ol);
`else
        got = 1'b0;
        mv  = 0;
        e_cyc = 0;
        repeat (int'(TIMEOUT_CYC) + 80) begin
            @(negedge clk);
            if (err_timeout === 1'b1) e_cyc++;
            if (m_valid === 1'b1) mv++;
        end
        n_checks++;
        if (e_cyc !== 0 || mv !== 0) begin
            n_fail++;
            $display("FAIL no_timeout_build: err pulses %0d m_valid %0d expected 0 0", e_cyc, mv);
        end
        rst_epoch++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        key_m = '0;
        ctr_m = '0;
        blk_m = 0;
        core_mute = 1'b0;
        load_cfg(rand128(), rand128());
        send_block(rand128(), 1'b1, 0, od, ol);
        n_checks++;
        if (got !== 1'b0 || h_cyc < 0) begin
            n_fail++;
            $display("FAIL no_timeout_state: internal flag %b", got);
        end
`endif
    endtask

    initial begin
        rst      = 1'b1;
        cfg_load = 1'b0;
        cfg_key  = '0;
        cfg_iv   = '0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        m_ready  = 1'b0;
        key_m    = '0;
        ctr_m    = '0;
        blk_m    = 0;
        test_reset();
        test_ctr_vector();
        test_round_trip();
        test_wrap();
        test_backpressure();
        test_load_with_valid();
        test_load_in_wait();
        test_random();
        test_reset_mid_wait();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_ctr_ctrl.md
AES_CTR_CTRL -- requirements
Module: aes_ctr_ctrl

Interface
REQ-001 SHALL have parameter CTR_W, default 32: width of the counter field (low bits of the counter block) that increments per block.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 64: maximum cycles in WAIT before abort (used only with AES_CTR_TIMEOUT_EN).
REQ-003 SHALL have one clock; reset is asynchronous and active-high. Ports: clk in 1, the single clock; rst in 1, asynchronous active-high reset.
REQ-004 Config ports SHALL be: cfg_load in 1, load pulse; cfg_key in 128, AES key; cfg_iv in 128, initial counter block.
REQ-005 Input stream SHALL be: s_valid in 1; s_ready out 1; s_data in 128, plaintext or ciphertext block; s_last in 1, final block of a message.
REQ-006 Output stream SHALL be: m_valid out 1; m_ready in 1; m_data out 128, result block; m_last out 1.
REQ-007 Core ports SHALL be: core_start out 1; core_encrypt out 1; core_data_in out 128; core_key_in out 128; core_data_out in 128; core_busy in 1; core_done in 1.
REQ-008 Status ports SHALL be: blk_count out 32, completed output blocks; err_timeout out 1, one-cycle abort pulse.

Function
REQ-009 SHALL implement CTR mode as the initiator of the core start/busy/done handshake: m_data = AES_enc(key_q, ctr_q) XOR data_q.
REQ-010 core_encrypt SHALL be constant 1; CTR decryption is the same operation.
REQ-011 FSM states SHALL be IDLE, ISSUE, WAIT, OUT.
REQ-012 IDLE: s_ready=1 unless cfg_load=1. s_valid&&s_ready captures s_data into data_q and s_last into last_q, then goes to ISSUE.
REQ-013 IDLE with cfg_load=1: load ctr_q<=cfg_iv and key_q<=cfg_key; s_ready=0 that cycle (load wins over a simultaneous s_valid).
REQ-014 cfg_load outside IDLE SHALL be ignored; key_q and ctr_q stay unchanged.
REQ-015 ISSUE: core_start=1 for exactly one cycle, with core_data_in=ctr_q and core_key_in=key_q held stable from ISSUE until core_done; then go to WAIT.
REQ-016 WAIT: on core_done=1, register m_data<=core_data_out^data_q and m_last<=last_q; increment ctr_q[CTR_W-1:0] modulo 2^CTR_W with ctr_q[127:CTR_W] untouched; go to OUT.
REQ-017 OUT: m_valid=1; m_data and m_last SHALL be held stable while m_ready=0. On m_ready=1: blk_count+=1 (wraps at 2^32), go to IDLE.
REQ-018 core_done in IDLE, ISSUE or OUT SHALL be ignored; core_busy is informational only.
REQ-019 Latency: input handshake at cycle N, core_start at N+1, m_valid at cycle D+1 where core_done is at cycle D; at most one block in flight.
REQ-020 After the m_last block is accepted, ctr_q SHALL NOT be reset; the next message requires cfg_load.

Reset
REQ-021 rst SHALL asynchronously force IDLE. All registers (ctr_q, key_q, data_q, last_q, m_data, blk_count, timeout counter) go to 0. Outputs go to: m_valid=0, m_last=0, core_start=0, err_timeout=0, m_data=0, blk_count=0.
REQ-022 Reset mid-operation SHALL discard the in-flight block with no output. A core_done arriving after reset is ignored per REQ-018.

Configuration
REQ-023 Macro AES_CTR_TIMEOUT_EN defined: a WAIT cycle counter runs. If core_done is absent for TIMEOUT_CYC cycles: err_timeout=1 for one cycle, go to IDLE, ctr_q not incremented, no output.
REQ-024 Macro AES_CTR_TIMEOUT_EN undefined: no counter is built, err_timeout is tied to 0, and WAIT waits indefinitely.

Structure
REQ-025 Package aes_ctr_pkg SHALL hold the state enum, the BLK_W=128 constant and the default TIMEOUT_CYC.
REQ-026 No sub-module: the core (aes_top) is instantiated by the integrator beside this block; the counter increment is inline.

Verification
REQ-027 Reset: rst=1 mid-WAIT -> next cycle IDLE, m_valid=0, blk_count=0, s_ready=1 after release; a late core_done produces no m_valid.
REQ-028 CTR vector: cfg_key=2b7e151628aed2a6abf7158809cf4f3c, cfg_iv=f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, s_data=6bc1bee22e409f96e93d7e117393172a -> m_data=874d6191b620e3261bef6864990db6ce. Then ae2d8a571e03ac9c9eb76fac45af8e51 -> 9806f66b7970fdff8617187bb9fffdff with s_last=1 -> m_last=1, blk_count=2.
REQ-029 Round trip: feed 874d6191b620e3261bef6864990db6ce after reloading the same key and iv -> m_data=6bc1bee22e409f96e93d7e117393172a.
REQ-030 Wrap: cfg_iv low 32 bits=ffffffff -> second core_data_in low 32 bits=00000000, upper 96 bits unchanged.
REQ-031 Backpressure and simultaneous events: m_ready=0 for 10 cycles -> m_data stable, s_ready=0. cfg_load with s_valid in IDLE -> load taken, s_ready=0 that cycle. cfg_load in WAIT -> ignored.
REQ-032 Timeout (AES_CTR_TIMEOUT_EN): stub core never asserts core_done -> err_timeout pulse 64 cycles after entering WAIT, IDLE, ctr_q unchanged.
